// File: rtl/aes_inv_shiftrow_stream_if.sv
// Valid/ready beat bus carrying one AES/Rijndael state plus a "last round" tag.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface aes_inv_shiftrow_stream_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/aes_inv_shiftrow_stream.sv
// InvShiftRows stage of the AES/Rijndael decryption round. Each row is rotated right by its offset.
// The stage is a valid/ready pipeline slot with a registered output and a one-entry skid buffer.
module aes_inv_shiftrow_stream #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  aes_inv_shiftrow_stream_if.slave  in_bus,
  aes_inv_shiftrow_stream_if.master out_bus,
  output logic [CNT_W-1:0]          beat_cnt
);

  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 8) begin : g_bad_nb
      $error("aes_inv_shiftrow_stream: NB must be 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [W-1:0]       main_data_r;
  logic               main_last_r;
  logic [W-1:0]       skid_data_r;
  logic               skid_last_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic               in_fire_s;
  logic               out_fire_s;
  logic [W-1:0]       xform_s;

  // Row offsets: 0/1/2/3 for a 128-bit block, 0/1/3/4 for a 256-bit block.
  function automatic int row_off(input int r);
    case (r)
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      3:       return (NB == 8) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  // Output byte j of row r takes input byte (j - off_r) mod NB of the same row.
  function automatic logic [W-1:0] inv_shift_rows(input logic [W-1:0] d);
    logic [W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < NB; j++) begin
        o[W-1-8*(r*NB+j) -: 8] = d[W-1-8*(r*NB+((j + NB - row_off(r)) % NB)) -: 8];
      end
    end
    return o;
  endfunction

  assign xform_s    = inv_shift_rows(in_bus.data);
  assign in_fire_s  = in_bus.valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_bus.ready;

  assign in_bus.ready  = in_ready_r;
  assign out_bus.valid = out_valid_r;
  assign out_bus.data  = main_data_r;
  assign out_bus.last  = main_last_r;
  assign beat_cnt      = beat_cnt_r;

  // Occupancy FSM: main register feeds the output, skid catches the beat accepted during a stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      main_data_r <= '0;
      main_last_r <= 1'b0;
      skid_data_r <= '0;
      skid_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          in_ready_r <= 1'b1;
          if (in_fire_s) begin
            state_r     <= ST_BUSY;
            out_valid_r <= 1'b1;
            main_data_r <= xform_s;
            main_last_r <= in_bus.last;
          end
        end
        ST_BUSY: begin
          if (in_fire_s && out_fire_s) begin
            main_data_r <= xform_s;
            main_last_r <= in_bus.last;
            in_ready_r  <= 1'b1;
          end else if (in_fire_s) begin
            state_r     <= ST_FULL;
            skid_data_r <= xform_s;
            skid_last_r <= in_bus.last;
            in_ready_r  <= 1'b0;
          end else if (out_fire_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            in_ready_r  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_r     <= ST_BUSY;
            main_data_r <= skid_data_r;
            main_last_r <= skid_last_r;
            in_ready_r  <= 1'b1;
          end else begin
            in_ready_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output transfer counter; wraps silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_r <= '0;
    end else if (out_fire_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end
  end

endmodule
